param_computational_unit: RTL
=============================

Name: param_computational_unit

Overview:
Parametrised next-generation datapath for the 4-bit microcontroller core. It provides the data registers, the data-bus source mux, an index register with a multi-bit extension counter, and an ALU with a result register and zero flag. Multiply is a sequential shift-add unit with a busy handshake, replacing the combinational multiplier. The block sits between the instruction decoder (which drives selects and enables) and the program/data memories and I/O pins.

Parameters:
DW, 4, data width of all data registers, data_bus, imm, dm, i_pins, r.
IDX_EXT, 1, width of the index extension counter above i (IDX_EXT >= 1).

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
source_sel  in  4  data_bus source select
alu_op  in  4  ALU operation code
imm  in  DW  immediate operand from instruction
i_pins  in  DW  input pins
dm  in  DW  data-memory read data
x_sel  in  1  ALU x operand: 0=x0, 1=x1
y_sel  in  1  ALU y operand: 0=y0, 1=y1
i_sel  in  1  i write source: 0=data_bus, 1=i+m
reg_en  in  9  write enables: [0]x0 [1]x1 [2]y0 [3]y1 [4]r [5]m [6]i [7]unused [8]o_reg
clr_ext  in  1  clear index extension
set_ext  in  1  set index extension to all ones
data_bus  out  DW  selected source
o_reg  out  DW  output register
i_ext  out  DW+IDX_EXT  {extension, i}
r  out  DW  ALU result register
r_eq_0  out  1  zero flag
busy  out  1  multiplier in progress

Behaviour:
- Reset (async): x0,x1,y0,y1,m,i,o_reg,r = 0; extension = 0; r_eq_0 = 1; busy = 0; multiplier state idle. A reset asserted mid-multiply aborts it; nothing is written.
- Data registers: on clk, a register loads data_bus when its reg_en bit is set; otherwise it holds.
- data_bus (combinational): 0 x0, 1 x1, 2 y0, 3 y1, 4 r, 5 m, 6 i, 7 dm, 8 imm, 9 i_pins, 10 extension zero-extended to DW, 11-15 zero.
- i: when reg_en[6] is set, i_sel=0 loads data_bus; i_sel=1 loads (i+m) mod 2^DW.
- Extension counter priority, highest first: clr_ext clears it; set_ext sets it to all ones; reg_en[6] with i_sel=1 and i+m >= 2^DW increments it mod 2^IDX_EXT; otherwise it holds.
- ALU ops (x,y after selection; results mod 2^DW): 0 -x; 1 x-y; 2 x+y; 3 MS DW bits of x*y; 4 LS DW bits of x*y; 5 x^y; 6 x&y; 7 ~x; 8-15 no-op (r and r_eq_0 hold).
- Single-cycle ops 0-2 and 5-7: when reg_en[4] is set and busy=0, r <= result and r_eq_0 <= (result==0) on the same edge.
- Multiply ops 3/4, FSM IDLE -> RUN -> IDLE:
  - Start: reg_en[4] with op 3 or 4 in IDLE. Operands and op are latched at the start edge E0; busy=1 after E0.
  - RUN performs one shift-add step per clock, DW steps.
  - At edge E0+DW, r <= selected half of the 2*DW product, r_eq_0 updates, busy returns to 0, and the FSM returns to IDLE. Latency is DW clocks.
- While busy=1:
  - reg_en[4] is ignored (no restart, r holds).
  - Other registers remain writable; changes to x/y do not affect the running product.
  - source_sel=4 returns the old r.
- No-op ops with reg_en[4] set do nothing and do not start the multiplier.

Optional Feature:
SAT_ARITH_EN
- Defined: ops 1 and 2 saturate unsigned. Add clamps to 2^DW-1; subtract with x<y yields 0. The zero flag follows the saturated value. All other ops are unchanged.
- Undefined: ops 1 and 2 wrap mod 2^DW.

Test Plan:
1. Pulse reset mid-run with arbitrary register contents -> immediately r=0, r_eq_0=1, busy=0, o_reg=0, i_ext=0; no write at the next edge.
2. DW=4: load x0=7, y0=3 via imm; op2, reg_en[4] -> r=0xA, r_eq_0=0. Then x0=3, op1 -> r=0, r_eq_0=1. Then op8 with reg_en[4] -> r=0, r_eq_0=1 held.
3. x0=0xD, y0=0xB, op3 -> busy high 4 cycles, then r=0x8. Repeat with op4 -> r=0xF. A reg_en[4] op2 issued during busy is ignored. x0 rewritten during busy -> product unchanged.
4. i=0xE, m=3, i_sel=1, reg_en[6] -> i=0x1, i_ext=0x11. Repeat until the next carry -> extension wraps to 0. clr_ext and a carry on the same edge -> extension=0. set_ext alone -> extension=1.
5. source_sel sweep 0-15 with distinct register values -> data_bus matches the map; 11-15 give 0.
6. x0=0xC, y0=6, op2 -> r=0xF with SAT_ARITH_EN, 0x2 without. x0=3, y0=5, op1 -> r=0x0 and r_eq_0=1 with SAT_ARITH_EN, 0xE without.

Source files
------------

// File: rtl/param_computational_unit_if.sv
// Decoder-facing bundle for param_computational_unit: selects/enables/operands in,
// bus, registers and status out.
interface param_computational_unit_if #(
   parameter int DW      = 4,
   parameter int IDX_EXT = 1
);
   logic [3:0]            source_sel;
   logic [3:0]            alu_op;
   logic [DW-1:0]         imm;
   logic [DW-1:0]         i_pins;
   logic [DW-1:0]         dm;
   logic                  x_sel;
   logic                  y_sel;
   logic                  i_sel;
   logic [8:0]            reg_en;
   logic                  clr_ext;
   logic                  set_ext;
   logic [DW-1:0]         data_bus;
   logic [DW-1:0]         o_reg;
   logic [DW+IDX_EXT-1:0] i_ext;
   logic [DW-1:0]         r;
   logic                  r_eq_0;
   logic                  busy;

   modport master (
      output source_sel, alu_op, imm, i_pins, dm, x_sel, y_sel, i_sel, reg_en, clr_ext, set_ext,
      input  data_bus, o_reg, i_ext, r, r_eq_0, busy
   );

   modport slave (
      input  source_sel, alu_op, imm, i_pins, dm, x_sel, y_sel, i_sel, reg_en, clr_ext, set_ext,
      output data_bus, o_reg, i_ext, r, r_eq_0, busy
   );
endinterface

// File: rtl/param_computational_unit.sv
// Datapath for the 4-bit MCU core: data registers, bus mux, index + extension, ALU with
// sequential shift-add multiplier. Optional macro SAT_ARITH_EN: unsigned saturating add/sub.
module param_computational_unit #(
   parameter int DW      = 4,
   parameter int IDX_EXT = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   param_computational_unit_if.slave bus
);
   localparam int CW = $clog2(DW) + 1;
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // gp[0..3] = x0, x1, y0, y1, enabled by reg_en[3:0]
   logic [3:0][DW-1:0]  gp_q, gp_d;
   logic [DW-1:0]       m_q, m_d;
   logic [DW-1:0]       i_q, i_d;
   logic [DW-1:0]       o_q, o_d;
   logic [IDX_EXT-1:0]  ext_q, ext_d;
   logic [DW-1:0]       r_q, r_d;
   logic                z_q, z_d;

   logic [0:0]          state_q, state_d;
   logic [2*DW-1:0]     mcand_q, mcand_d;
   logic [DW-1:0]       mplier_q, mplier_d;
   logic [2*DW-1:0]     acc_q, acc_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                hi_q, hi_d;

   logic [DW-1:0]       data_bus;
   logic [DW-1:0]       x_op, y_op;
   logic [DW:0]         i_sum, add_w, sub_w;
   logic [DW-1:0]       alu_res;
   logic                single_op, mul_op, mul_start, mul_last;
   logic [2*DW-1:0]     acc_step;
   logic [DW-1:0]       mul_res;
   logic                unused_en7;

   assign unused_en7 = bus.reg_en[7];

   // ---------------- data bus source mux ----------------
   always_comb begin
      data_bus = '0;
      case (bus.source_sel)
         4'd0:    data_bus = gp_q[0];
         4'd1:    data_bus = gp_q[1];
         4'd2:    data_bus = gp_q[2];
         4'd3:    data_bus = gp_q[3];
         4'd4:    data_bus = r_q;
         4'd5:    data_bus = m_q;
         4'd6:    data_bus = i_q;
         4'd7:    data_bus = bus.dm;
         4'd8:    data_bus = bus.imm;
         4'd9:    data_bus = bus.i_pins;
         4'd10:   data_bus = DW'(ext_q);
         default: data_bus = '0;
      endcase
   end

   // ---------------- plain data registers ----------------
   always_comb begin
      gp_d = gp_q;
      for (int k = 0; k < 4; k++) begin
         if (bus.reg_en[k]) gp_d[k] = data_bus;
      end
      m_d = bus.reg_en[5] ? data_bus : m_q;
      o_d = bus.reg_en[8] ? data_bus : o_q;
   end

   // ---------------- index and extension ----------------
   assign i_sum = {1'b0, i_q} + {1'b0, m_q};

   always_comb begin
      i_d = i_q;
      if (bus.reg_en[6]) i_d = bus.i_sel ? i_sum[DW-1:0] : data_bus;
   end

   always_comb begin
      ext_d = ext_q;
      if (bus.clr_ext)
         ext_d = '0;
      else if (bus.set_ext)
         ext_d = '1;
      else if (bus.reg_en[6] && bus.i_sel && i_sum[DW])
         ext_d = ext_q + IDX_EXT'(1);
   end

   // ---------------- single-cycle ALU ----------------
   assign x_op  = bus.x_sel ? gp_q[1] : gp_q[0];
   assign y_op  = bus.y_sel ? gp_q[3] : gp_q[2];
   assign add_w = {1'b0, x_op} + {1'b0, y_op};
   assign sub_w = {1'b0, x_op} - {1'b0, y_op};

   always_comb begin
      alu_res = '0;
      case (bus.alu_op)
         4'd0: alu_res = '0 - x_op;
`ifdef SAT_ARITH_EN
         // sub_w[DW] is the borrow, add_w[DW] the carry
         4'd1: alu_res = sub_w[DW] ? '0 : sub_w[DW-1:0];
         4'd2: alu_res = add_w[DW] ? '1 : add_w[DW-1:0];
`else
         4'd1: alu_res = sub_w[DW-1:0];
         4'd2: alu_res = add_w[DW-1:0];
`endif
         4'd5: alu_res = x_op ^ y_op;
         4'd6: alu_res = x_op & y_op;
         4'd7: alu_res = ~x_op;
         default: alu_res = '0;
      endcase
   end

   assign single_op = (bus.alu_op <= 4'd2) || (bus.alu_op >= 4'd5 && bus.alu_op <= 4'd7);
   assign mul_op    = (bus.alu_op == 4'd3) || (bus.alu_op == 4'd4);
   assign mul_start = bus.reg_en[4] && (state_q == ST_IDLE) && mul_op;

   // ---------------- shift-add multiplier ----------------
   assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
   assign mul_last = (cnt_q == CW'(DW - 1));
   assign mul_res  = hi_q ? acc_step[2*DW-1:DW] : acc_step[DW-1:0];

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      if (state_q == ST_IDLE) begin
         if (mul_start) begin
            state_d  = ST_RUN;
            mcand_d  = {{DW{1'b0}}, x_op};
            mplier_d = y_op;
            acc_d    = '0;
            cnt_d    = '0;
            hi_d     = (bus.alu_op == 4'd3);
         end
      end else begin
         acc_d    = acc_step;
         mcand_d  = {mcand_q[2*DW-2:0], 1'b0};
         mplier_d = {1'b0, mplier_q[DW-1:1]};
         cnt_d    = cnt_q + CW'(1);
         if (mul_last) state_d = ST_IDLE;
      end
   end

   // ---------------- result register and zero flag ----------------
   always_comb begin
      r_d = r_q;
      z_d = z_q;
      if (state_q == ST_IDLE) begin
         if (bus.reg_en[4] && single_op) begin
            r_d = alu_res;
            z_d = (alu_res == '0);
         end
      end else if (mul_last) begin
         r_d = mul_res;
         z_d = (mul_res == '0);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gp_q     <= '0;
         m_q      <= '0;
         i_q      <= '0;
         o_q      <= '0;
         ext_q    <= '0;
         r_q      <= '0;
         z_q      <= 1'b1;
         state_q  <= ST_IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         hi_q     <= 1'b0;
      end else begin
         gp_q     <= gp_d;
         m_q      <= m_d;
         i_q      <= i_d;
         o_q      <= o_d;
         ext_q    <= ext_d;
         r_q      <= r_d;
         z_q      <= z_d;
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
      end
   end

   assign bus.data_bus = data_bus;
   assign bus.o_reg    = o_q;
   assign bus.i_ext    = {ext_q, i_q};
   assign bus.r        = r_q;
   assign bus.r_eq_0   = z_q;
   assign bus.busy     = (state_q == ST_RUN);
endmodule
